stopwatch_bcd: RTL and testbench



---
 rtl/stopwatch_bcd.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch advanced by edges of a slow divided clock, with start/stop/clear control.
// Optional lap/freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int BOTH_EDGES = 0,
    parameter int MIN_LIMIT  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic       lap_active
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [3:0] LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_O = 4'(MIN_LIMIT % 10);

    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q;
    logic [3:0] so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
    logic       wrap_q, wrap_d;
    logic       roll_q;
    logic [15:0] disp_q, show;
    logic [15:0] live;
    logic       tick_pulse;
    logic       at_limit;

    assign live       = {mt_q, mo_q, st_q, so_q};
    assign tick_pulse = (BOTH_EDGES != 0) ? (s2_q ^ s3_q) : (s2_q & ~s3_q);
    assign at_limit   = (mt_q == LIM_T) && (mo_q == LIM_O);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tick_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        so_d    = so_q;
        st_d    = st_q;
        mo_d    = mo_q;
        mt_d    = mt_q;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            so_d    = 4'd0;
            st_d    = 4'd0;
            mo_d    = 4'd0;
            mt_d    = 4'd0;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if (state_q != RUN) state_d = RUN;
        end else if (tick_pulse && state_q == RUN) begin
            // Ripple carry through the BCD digits; the minute limit overrides the normal carry.
            if (so_q == 4'd9) begin
                so_d = 4'd0;
                if (st_q == 4'd5) begin
                    st_d = 4'd0;
                    if (at_limit) begin
                        mo_d   = 4'd0;
                        mt_d   = 4'd0;
                        wrap_d = 1'b1;
                    end else if (mo_q == 4'd9) begin
                        mo_d = 4'd0;
                        mt_d = mt_q + 4'd1;
                    end else begin
                        mo_d = mo_q + 4'd1;
                    end
                end else begin
                    st_d = st_q + 4'd1;
                end
            end else begin
                so_d = so_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            so_q    <= 4'd0;
            st_q    <= 4'd0;
            mo_q    <= 4'd0;
            mt_q    <= 4'd0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            so_q    <= so_d;
            st_q    <= st_d;
            mo_q    <= mo_d;
            mt_q    <= mt_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_q, lap_d;
    logic [15:0] frz_q, frz_d;

    always_comb begin
        lap_d = lap_q;
        frz_d = frz_q;
        if (clear) begin
            lap_d = 1'b0;
        end else if (lap) begin
            if (lap_q) begin
                lap_d = 1'b0;
            end else if (state_q == RUN) begin
                lap_d = 1'b1;
                frz_d = live;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            frz_q <= 16'd0;
        end else begin
            lap_q <= lap_d;
            frz_q <= frz_d;
        end
    end

    assign show       = lap_q ? frz_q : live;
    assign lap_active = lap_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign show       = live;
    assign lap_active = 1'b0;
`endif

    // Output stage: digits and rollover leave together, one cycle after the count update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= 16'd0;
            roll_q <= 1'b0;
        end else begin
            disp_q <= show;
            roll_q <= wrap_q;
        end
    end

    assign sec_ones = disp_q[3:0];
    assign sec_tens = disp_q[7:4];
    assign min_ones = disp_q[11:8];
    assign min_tens = disp_q[15:12];
    assign rollover = roll_q;
    assign running  = (state_q == RUN);
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench: three stopwatch instances (default, MIN_LIMIT=1, BOTH_EDGES=1) share stimulus.
module tb_stopwatch_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_in = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [2:0][3:0] so, st, mo, mt;
    logic [2:0] run, roll, lapa;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stopwatch_bcd #(
            .BOTH_EDGES((g == 2) ? 1 : 0),
            .MIN_LIMIT ((g == 1) ? 1 : 59)
        ) u_dut (
            .clk(clk), .rst(rst), .tick_in(tick_in),
            .start(start), .stop(stop), .clear(clear), .lap(lap),
            .sec_ones(so[g]), .sec_tens(st[g]), .min_ones(mo[g]), .min_tens(mt[g]),
            .running(run[g]), .rollover(roll[g]), .lap_active(lapa[g])
        );
    end

    typedef struct {
        int          dut;
        logic [15:0] dig;
        logic        run;
        logic        lapa;
        int          rolls;   // -1: not checked
        string       name;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nfail = 0;
    int   roll_cnt[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (roll[g]) begin
                roll_cnt[g]++;
                nvec++;
                if ({mt[g], mo[g], st[g], so[g]} != 16'h0000) begin
                    nfail++;
                    $display("FAIL roll_align dut%0d: digits %h while rollover, need 0000", g,
                             {mt[g], mo[g], st[g], so[g]});
                end
            end
        end
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] d;
            e = q.pop_front();
            d = {mt[e.dut], mo[e.dut], st[e.dut], so[e.dut]};
            nvec++;
            if (d !== e.dig || run[e.dut] !== e.run || lapa[e.dut] !== e.lapa ||
                (e.rolls >= 0 && roll_cnt[e.dut] != e.rolls)) begin
                nfail++;
                $display("FAIL %s dut%0d: got %h run=%b lap=%b rolls=%0d, need %h run=%b lap=%b rolls=%0d",
                         e.name, e.dut, d, run[e.dut], lapa[e.dut], roll_cnt[e.dut],
                         e.dig, e.run, e.lapa, e.rolls);
            end
        end
    end

    task automatic expect_out(input int dut, input logic [15:0] dig, input logic r,
                              input logic la, input int rolls, input string name);
        exp_t e;
        e.dut = dut; e.dig = dig; e.run = r; e.lapa = la; e.rolls = rolls; e.name = name;
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Command held for exactly one sampling edge, then one more cycle for the outputs to settle.
    task automatic pulse(input logic s, input logic p, input logic c, input logic l);
        @(negedge clk);
        start = s; stop = p; clear = c; lap = l;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        @(negedge clk);
    endtask

    task automatic toggles(input int n);
        repeat (n) begin
            @(negedge clk);
            tick_in = ~tick_in;
            cyc(4);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) toggles(2);
    endtask

    int base;

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);
        expect_out(0, 16'h0000, 1'b0, 1'b0, 0, "reset");

        pulse(1, 0, 0, 0);
        expect_out(0, 16'h0000, 1'b1, 1'b0, -1, "start_running");
        ticks(75);
        expect_out(0, 16'h0115, 1'b1, 1'b0, 0, "count_75");

        pulse(0, 0, 1, 0);
        expect_out(0, 16'h0000, 1'b0, 1'b0, -1, "clear");
        pulse(1, 0, 0, 0);
        ticks(42);
        expect_out(0, 16'h0042, 1'b1, 1'b0, -1, "count_42");
        pulse(0, 1, 0, 0);
        expect_out(0, 16'h0042, 1'b0, 1'b0, -1, "stop");
        ticks(10);
        expect_out(0, 16'h0042, 1'b0, 1'b0, -1, "paused_hold");
        pulse(1, 0, 0, 0);
        ticks(1);
        expect_out(0, 16'h0043, 1'b1, 1'b0, -1, "resume_43");

        // start (ignored in RUN) coincident with a tick pulse drops the tick
        @(negedge clk);
        tick_in = 1'b1;
        cyc(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(2);
        tick_in = 1'b0;
        cyc(4);
        expect_out(0, 16'h0043, 1'b1, 1'b0, -1, "tick_vs_cmd");

        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        ticks(30);
        pulse(0, 1, 0, 0);
        expect_out(0, 16'h0030, 1'b0, 1'b0, -1, "pause_30");
        pulse(1, 0, 1, 0);
        expect_out(0, 16'h0000, 1'b0, 1'b0, -1, "clear_over_start");

        // MIN_LIMIT=1 instance wraps after 01:59
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        base = roll_cnt[1];
        ticks(119);
        expect_out(1, 16'h0159, 1'b1, 1'b0, base, "limit_0159");
        ticks(1);
        expect_out(1, 16'h0000, 1'b1, 1'b0, base + 1, "limit_wrap");

        // BOTH_EDGES=1 instance counts every level change
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        ticks(4);
        expect_out(2, 16'h0008, 1'b1, 1'b0, -1, "both_edges_8");
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        toggles(5);
        expect_out(2, 16'h0005, 1'b1, 1'b0, -1, "both_edges_5");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        nvec++;
        if ({mt[2], mo[2], st[2], so[2]} !== 16'h0000 || run[2] !== 1'b0 || roll[2] !== 1'b0) begin
            nfail++;
            $display("FAIL async_rst: got %h run=%b roll=%b before clk edge, need 0000 run=0 roll=0",
                     {mt[2], mo[2], st[2], so[2]}, run[2], roll[2]);
        end
        cyc(2);
        rst = 1'b0;
        toggles(2);
        expect_out(2, 16'h0000, 1'b0, 1'b0, -1, "after_rst_idle");

        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        ticks(10);
        expect_out(0, 16'h0010, 1'b1, 1'b0, -1, "lap_pre_10");
        pulse(0, 0, 0, 1);
        ticks(5);
`ifdef STOPWATCH_LAP_EN
        expect_out(0, 16'h0010, 1'b1, 1'b1, -1, "lap_frozen");
        pulse(0, 0, 0, 1);
        expect_out(0, 16'h0015, 1'b1, 1'b0, -1, "lap_release");
`else
        expect_out(0, 16'h0015, 1'b1, 1'b0, -1, "lap_ignored");
`endif

        cyc(2);
        if (q.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end
endmodule
